// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller: FSM encoding,
// counter width and the grouped stage-control bundles.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam int CNT_W  = 32;
    localparam int WAIT_W = 8;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } wr_en_t;

    typedef struct packed {
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } flush_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: an EX-stage load whose destination feeds the
// ID-stage instruction. Register 0 is hardwired, so it never hazards.
module hazard_detect (
    input  logic       ex_mem_read,
    input  logic [4:0] ex_write_addr,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       load_use
);

    assign load_use = ex_mem_read && (ex_write_addr != 5'd0) &&
                      ((ex_write_addr == id_rs) || (ex_write_addr == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: memory stall FSM, load-use stall, branch flush and perf
// counters. Define PIPE_MEM_TIMEOUT_EN to add the MEM_WAIT timeout / FAULT path.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_write_addr,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_wr_en,
    output logic             if_id_wr_en,
    output logic             id_ex_wr_en,
    output logic             ex_mem_wr_en,
    output logic             mem_wb_wr_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`ifdef PIPE_MEM_TIMEOUT_EN
    ,
    output logic             mem_timeout
`endif
);

    state_t state_q, state_d;
    wr_en_t wr_en;
    flush_t flush;
    logic   load_use;
    logic   mem_stall;
    logic   lu_stall;
    logic   br_flush;
    logic   timeout_hit;

    hazard_detect u_hazard (
        .ex_mem_read   (ex_mem_read),
        .ex_write_addr (ex_write_addr),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .load_use      (load_use)
    );

    // Lower-priority events only act in RUN and only when memory is not stalling.
    always_comb begin
        mem_stall = ((state_q == RUN) && mem_req && !mem_ready) ||
                    ((state_q == MEM_WAIT) && !mem_ready);
        lu_stall  = (state_q == RUN) && !mem_stall && load_use;
        br_flush  = (state_q == RUN) && !mem_stall && !load_use &&
                    (id_branch_taken || id_jump);
    end

`ifdef PIPE_MEM_TIMEOUT_EN
    logic [WAIT_W-1:0] wait_cnt;

    assign timeout_hit = (state_q == MEM_WAIT) && !mem_ready &&
                         (wait_cnt >= WAIT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (state_q == RUN && state_d == MEM_WAIT)
                wait_cnt <= '0;
            else if (state_q == MEM_WAIT)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (state_q == MEM_WAIT && state_d == FAULT)
                mem_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    // mem_ready wins over a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mem_req && !mem_ready) state_d = MEM_WAIT;
            MEM_WAIT: begin
                if (mem_ready)        state_d = RUN;
                else if (timeout_hit) state_d = FAULT;
            end
`ifdef PIPE_MEM_TIMEOUT_EN
            FAULT:    state_d = FAULT;
`endif
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        wr_en = '1;
        flush = '0;
        if (!reset) begin
            wr_en = '0;
            flush = '1;
`ifdef PIPE_MEM_TIMEOUT_EN
        end else if (state_q == FAULT) begin
            wr_en = '0;
`endif
        end else if (mem_stall) begin
            wr_en.pc     = 1'b0;
            wr_en.if_id  = 1'b0;
            wr_en.id_ex  = 1'b0;
            wr_en.ex_mem = 1'b0;
            flush.mem_wb = 1'b1;
        end else if (lu_stall) begin
            wr_en.pc    = 1'b0;
            wr_en.if_id = 1'b0;
            flush.id_ex = 1'b1;
        end else if (br_flush) begin
            flush.if_id = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state_q != FAULT) begin
            if (mem_stall || lu_stall) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush.if_id)           flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign pc_wr_en     = wr_en.pc;
    assign if_id_wr_en  = wr_en.if_id;
    assign id_ex_wr_en  = wr_en.id_ex;
    assign ex_mem_wr_en = wr_en.ex_mem;
    assign mem_wb_wr_en = wr_en.mem_wb;
    assign if_id_flush  = flush.if_id;
    assign id_ex_flush  = flush.id_ex;
    assign ex_mem_flush = flush.ex_mem;
    assign mem_wb_flush = flush.mem_wb;
    assign state        = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed cases plus random traffic,
// predicted by a cycle-level behavioural model of the priority rules.
module tb_pipeline_ctrl;

    localparam int T = 4;

    logic        clk = 1'b1;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_write_addr;
    logic        ex_mem_read, id_branch_taken, id_jump, mem_req, mem_ready;
    logic        pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;
`ifdef PIPE_MEM_TIMEOUT_EN
    logic        mem_timeout;
`endif

    pipeline_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_write_addr(ex_write_addr),
        .id_branch_taken(id_branch_taken), .id_jump(id_jump),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_wr_en(pc_wr_en), .if_id_wr_en(if_id_wr_en), .id_ex_wr_en(id_ex_wr_en),
        .ex_mem_wr_en(ex_mem_wr_en), .mem_wb_wr_en(mem_wb_wr_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`ifdef PIPE_MEM_TIMEOUT_EN
        , .mem_timeout(mem_timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk;
        logic [4:0]  wr;
        logic [3:0]  fl;
        logic [1:0]  st;
        logic [31:0] sc;
        logic [31:0] fc;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model state
    bit          m_known = 0, m_wait = 0, m_fault = 0, m_to = 0;
    int          m_wcnt = 0;
    logic [31:0] m_sc = 0, m_fc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("wr_en", {27'd0, pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en},
                      {27'd0, e.wr});
                check("flush", {28'd0, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush},
                      {28'd0, e.fl});
                if (e.chk) begin
                    check("state", {30'd0, state}, {30'd0, e.st});
                    check("stall_cnt", stall_cnt, e.sc);
                    check("flush_cnt", flush_cnt, e.fc);
`ifdef PIPE_MEM_TIMEOUT_EN
                    check("mem_timeout", {31'd0, mem_timeout}, {31'd0, e.to});
`endif
                end
            end
        end
    end

    task automatic set_in(input bit rst_n, input int rs, input int rt, input bit rd, input int wa,
                          input bit br, input bit jp, input bit req, input bit rdy);
        reset = rst_n; id_rs = 5'(rs); id_rt = 5'(rt); ex_mem_read = rd;
        ex_write_addr = 5'(wa); id_branch_taken = br; id_jump = jp;
        mem_req = req; mem_ready = rdy;
    endtask

    // Predict this cycle's outputs from the current inputs, then advance the model.
    task automatic step();
        exp_t e;
        bit   lu, ms;
        e.chk = m_known;
        e.st  = m_fault ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
        e.sc  = m_sc;
        e.fc  = m_fc;
        e.to  = m_to;
        lu = ex_mem_read && ex_write_addr != 0 &&
             (ex_write_addr == id_rs || ex_write_addr == id_rt);
        ms = !m_fault && (m_wait ? !mem_ready : (mem_req && !mem_ready));
        e.wr = 5'b11111;
        e.fl = 4'b0000;
        if (!reset) begin
            e.wr = 5'b00000; e.fl = 4'b1111;
            m_known = 1; m_wait = 0; m_fault = 0; m_to = 0; m_wcnt = 0; m_sc = 0; m_fc = 0;
        end else if (m_fault) begin
            e.wr = 5'b00000;
        end else if (ms) begin
            e.wr = 5'b00001; e.fl = 4'b0001;
            m_sc = m_sc + 1;
            if (!m_wait) begin
                m_wait = 1; m_wcnt = 0;
            end else begin
`ifdef PIPE_MEM_TIMEOUT_EN
                if (m_wcnt >= T) begin m_fault = 1; m_wait = 0; m_to = 1; end
`endif
                m_wcnt++;
            end
        end else if (m_wait) begin
            m_wait = 0;
        end else if (lu) begin
            e.wr = 5'b00111; e.fl = 4'b0100;
            m_sc = m_sc + 1;
        end else if (id_branch_taken || id_jump) begin
            e.fl = 4'b1000;
            m_fc = m_fc + 1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(); step();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1); step();
        // load-use on rt, then same with r0 destination
        set_in(1, 1, 5, 1, 5, 0, 0, 0, 1); step();
        set_in(1, 1, 5, 1, 0, 0, 0, 0, 1); step();
        set_in(1, 5, 2, 1, 5, 0, 0, 0, 1); step();
        // load-use beats branch, then branch alone
        set_in(1, 3, 4, 1, 3, 1, 0, 0, 1); step();
        set_in(1, 3, 4, 0, 3, 1, 0, 0, 1); step();
        set_in(1, 3, 4, 0, 3, 0, 1, 0, 1); step();
        // memory wait: 3 stall cycles then ready
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0); step(); step(); step();
        set_in(1, 0, 0, 0, 0, 1, 0, 1, 1); step();
        set_in(1, 0, 0, 1, 7, 1, 0, 0, 1); step();
        // reset mid-MEM_WAIT
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        // stall counter wrap
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt;
        m_sc = 32'hFFFF_FFFF;
        set_in(1, 9, 2, 1, 9, 0, 0, 0, 1); step();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1); step();
`ifdef PIPE_MEM_TIMEOUT_EN
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < T + 6; i++) step();
        set_in(1, 0, 0, 1, 3, 1, 0, 1, 1); step(); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1); step();
`endif
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 59) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   1'($urandom_range(0, 1)), $urandom_range(0, 7),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
            step();
        end
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: MEM_WAIT cycles before fault. Used only with PIPE_MEM_TIMEOUT_EN.
REQ-002 clk  in  1  clock; all state updates on posedge.
REQ-003 reset  in  1  reset, synchronous, active-low.
REQ-004 id_rs, id_rt  in  5 each  source register addresses of the ID-stage instruction.
REQ-005 ex_mem_read  in  1  EX-stage instruction is a load.
REQ-006 ex_write_addr  in  5  EX-stage destination register.
REQ-007 id_branch_taken, id_jump  in  1 each  branch taken / jump resolved in ID.
REQ-008 mem_req, mem_ready  in  1 each  MEM stage accesses memory / memory completes this cycle.
REQ-009 pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en  out  1 each  stage write enables.
REQ-010 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  active-high clear into the stage register.
REQ-011 state  out  2  FSM state, for debug.
REQ-012 stall_cnt, flush_cnt  out  32 each  performance counters.
REQ-013 mem_timeout  out  1  sticky fault flag. Present only with PIPE_MEM_TIMEOUT_EN.

Function
REQ-014 The FSM SHALL have these states and encodings:
- RUN = 0
- MEM_WAIT = 1
- FAULT = 2
REQ-015 Outputs SHALL be combinational from the state and the inputs, with no extra latency. Defaults: all wr_en = 1, all flush = 0.
REQ-016 Priority SHALL be: FAULT > memory stall > load-use > branch/jump.
REQ-017 Memory stall SHALL apply when (RUN and mem_req and !mem_ready) or (MEM_WAIT and !mem_ready). It SHALL:
- set pc, if_id, id_ex and ex_mem wr_en = 0;
- set mem_wb_flush = 1.
REQ-018 Memory stall transitions:
- RUN to MEM_WAIT on the next edge.
- MEM_WAIT with mem_ready = 1: defaults apply that cycle and the FSM returns to RUN.
REQ-019 Load-use hazard SHALL be: ex_mem_read and ex_write_addr != 0 and (ex_write_addr == id_rs or ex_write_addr == id_rt).
REQ-020 On load-use in RUN with no memory stall: pc_wr_en = 0, if_id_wr_en = 0, id_ex_flush = 1. No state change.
REQ-021 If load-use coincides with id_branch_taken or id_jump, load-use SHALL win and if_id_flush = 0; the branch re-resolves next cycle.
REQ-022 On branch or jump in RUN with no higher-priority event: if_id_flush = 1.
REQ-023 stall_cnt SHALL increment by 1 per cycle of memory stall or load-use.
REQ-024 flush_cnt SHALL increment by 1 per cycle with if_id_flush = 1.
REQ-025 Both counters SHALL wrap from 0xFFFFFFFF to 0 and SHALL not saturate.
REQ-026 In FAULT: all wr_en = 0, all flush = 0, counters frozen. FAULT SHALL be left only via reset.

Reset
REQ-027 While reset == 0, on each clock edge: state = RUN, stall_cnt = 0, flush_cnt = 0, wait counter = 0, mem_timeout = 0.
REQ-028 While reset == 0, outputs SHALL be forced combinationally: all wr_en = 0, all flush = 1.
REQ-029 Reset asserted mid-MEM_WAIT or in FAULT SHALL return the FSM to RUN on the next edge, regardless of mem_ready.

Configuration
REQ-030 With PIPE_MEM_TIMEOUT_EN defined:
- an 8-bit wait counter SHALL be cleared on entry to MEM_WAIT and incremented each cycle in MEM_WAIT;
- when it reaches TIMEOUT_CYCLES with mem_ready = 0, the next state SHALL be FAULT and mem_timeout SHALL be set (sticky);
- mem_ready in that same cycle SHALL take precedence (return to RUN, no fault).
REQ-031 Without PIPE_MEM_TIMEOUT_EN:
- the wait counter, the FAULT state and the mem_timeout port SHALL be absent;
- MEM_WAIT SHALL wait indefinitely.

Structure
REQ-032 Package pipe_ctrl_pkg SHALL hold the state encoding (RUN, MEM_WAIT, FAULT) and the counter width constant (32).
REQ-033 Sub-module hazard_detect SHALL implement the combinational load-use compare (REQ-019) and output a single bit.

Verification
REQ-034 Reset: reset = 0 for 2 cycles -> state = 0, counters = 0, all flush = 1, all wr_en = 0. Release -> all wr_en = 1, all flush = 0.
REQ-035 Load-use: ex_mem_read = 1, ex_write_addr = 5, id_rt = 5 for 1 cycle -> pc_wr_en = 0, if_id_wr_en = 0, id_ex_flush = 1, stall_cnt = 1. Same case with ex_write_addr = 0 -> no stall.
REQ-036 Load-use plus id_branch_taken = 1 together -> if_id_flush = 0, flush_cnt unchanged. Branch alone next cycle -> if_id_flush = 1, flush_cnt = 1.
REQ-037 Memory wait: mem_req = 1, mem_ready = 0 for 3 cycles, then mem_ready = 1 -> stall outputs for 3 cycles, state = 1 after the first edge, then RUN, stall_cnt = 3.
REQ-038 Timeout (macro on, TIMEOUT_CYCLES = 4): mem_req = 1, mem_ready held 0 -> FAULT with mem_timeout = 1 and all wr_en = 0. mem_ready = 1 later -> still FAULT. Reset -> RUN.
REQ-039 Counter wrap: preload stall_cnt = 0xFFFFFFFF via force, one load-use cycle -> stall_cnt = 0.
